serial_bus_arbiter_rr: RTL and testbench

// - Next-generation serial-bus interconnect: NUM_MASTERS masters share NUM_SLAVES slaves.
// - Round-robin grant; granted master clocks a SEL_W-bit slave select in serially, MSB first.
// - Block then routes address/data/valid to the selected slave and its ready back.
// - Holds the connection until the master drops its request; sits between master and slave ports of the bus.

---
 rtl/serial_bus_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/serial_bus_arbiter_rr.sv | 186 ++++++++++++++++++
 tb/tb_serial_bus_arbiter_rr.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial-bus round-robin arbiter.
package serial_bus_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PAUSE   = 2'd2,
    CONNECT = 2'd3
  } state_t;

  // Widest one-hot vector the routing helper handles.
  localparam int ROUTE_W = 32;

  // Drive a single serial bit onto the one-hot lanes that are selected.
  function automatic logic [ROUTE_W-1:0] route_onehot(input logic [ROUTE_W-1:0] onehot,
                                                      input logic               bit_in);
    return bit_in ? onehot : '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the pointer with wrap-around; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % NUM_MASTERS);
      if (!o_any && i_req[w_cand]) begin
        o_any          = 1'b1;
        o_idx          = w_cand;
        o_grant        = '0;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter_rr.sv
// Round-robin serial-bus arbiter: grant, serial slave select, routed connection.
// Optional feature: define ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES
// consecutive idle-valid cycles in CONNECT.
module serial_bus_arbiter_rr
  import serial_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_err,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  input  logic [NUM_SLAVES-1:0]  s_ready
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(SEL_W + 1);

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]       r_gidx, w_gidx_nxt;
  logic [NUM_SLAVES-1:0]  r_conn, w_conn_nxt;
  logic [SEL_W-1:0]       r_sel, w_sel_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
  logic [NUM_MASTERS-1:0] r_err, w_err_nxt;

  logic [NUM_MASTERS-1:0] w_arb_grant;
  logic [IDX_W-1:0]       w_arb_idx;
  logic                   w_arb_any;
  logic [IDX_W-1:0]       w_ptr_inc;
  logic                   w_req_g;
  logic                   w_addr_g;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             w_valid_g;
  assign w_valid_g = m_valid[r_gidx];
`endif

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_rr_arbiter (
    .i_req  (m_req),
    .i_ptr  (r_ptr),
    .o_grant(w_arb_grant),
    .o_idx  (w_arb_idx),
    .o_any  (w_arb_any)
  );

  assign w_req_g   = m_req[r_gidx];
  assign w_addr_g  = m_address[r_gidx];
  assign w_ptr_inc = (r_gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_gidx + 1'b1;

  // Next-state and next-register logic for the transaction FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_conn_nxt  = r_conn;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_err_nxt   = '0;
`ifdef ARB_TIMEOUT_EN
    w_tmo_nxt   = r_tmo;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_grant_nxt = w_arb_grant;
          w_gidx_nxt  = w_arb_idx;
          w_sel_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (!w_req_g) begin
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = IDLE;
        end else begin
          // Cast keeps the low SEL_W bits, so SEL_W=1 needs no special case.
          w_sel_nxt = SEL_W'({r_sel, w_addr_g});
          w_cnt_nxt = r_cnt + 1'b1;
          if (32'(r_cnt) == SEL_W - 1) w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (!w_req_g) begin
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = IDLE;
        end else if (32'(r_sel) < NUM_SLAVES) begin
          w_conn_nxt  = NUM_SLAVES'(1) << r_sel;
          w_state_nxt = CONNECT;
`ifdef ARB_TIMEOUT_EN
          w_tmo_nxt   = '0;
`endif
        end else begin
          w_err_nxt   = r_grant;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = IDLE;
        end
      end
      CONNECT: begin
        if (!w_req_g) begin
          w_grant_nxt = '0;
          w_conn_nxt  = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_valid_g) begin
          w_tmo_nxt = '0;
        end else if (32'(r_tmo) == TIMEOUT_CYCLES - 1) begin
          w_err_nxt   = r_grant;
          w_grant_nxt = '0;
          w_conn_nxt  = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant, connection, select shifter, pointer and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_conn  <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_err   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_conn  <= w_conn_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_err   <= w_err_nxt;
`ifdef ARB_TIMEOUT_EN
      r_tmo   <= w_tmo_nxt;
`endif
    end
  end

  assign m_grant   = r_grant;
  assign m_err     = r_err;
  assign s_address = NUM_SLAVES'(route_onehot(ROUTE_W'(r_conn), w_addr_g));
  assign s_data    = NUM_SLAVES'(route_onehot(ROUTE_W'(r_conn), m_data[r_gidx]));
  assign s_valid   = NUM_SLAVES'(route_onehot(ROUTE_W'(r_conn), m_valid[r_gidx]));
  assign m_ready   = NUM_MASTERS'(route_onehot(ROUTE_W'(r_grant), |(r_conn & s_ready)));

endmodule

// File: tb/tb_serial_bus_arbiter_rr.sv
// Self-checking bench for serial_bus_arbiter_rr (2 masters, 3 slaves, 2 select bits).
module tb_serial_bus_arbiter_rr;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] m_req, m_address, m_data, m_valid;
  logic [NM-1:0] m_grant, m_ready, m_err;
  logic [NS-1:0] s_address, s_data, s_valid, s_ready;

  int n_checks = 0;
  int n_errors = 0;
  int mptr     = 0;

  always #5 clk = ~clk;

  serial_bus_arbiter_rr #(
    .NUM_MASTERS   (NM),
    .NUM_SLAVES    (NS),
    .SEL_W         (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_address(m_address),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_grant  (m_grant),
    .m_ready  (m_ready),
    .m_err    (m_err),
    .s_address(s_address),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NM-1:0] req);
    int c;
    for (int k = 0; k < NM; k++) begin
      c = (mptr + k) % NM;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  // Expected outputs: given grant/err, and (if sel >= 0) master g routed to slave sel.
  function automatic logic [14:0] model_out(input logic [NM-1:0] grant, input logic [NM-1:0] err,
                                            input int g, input int sel);
    logic [NS-1:0] sa, sd, sv;
    logic [NM-1:0] mr;
    sa = '0; sd = '0; sv = '0; mr = '0;
    if (sel >= 0) begin
      sa[sel] = m_address[g];
      sd[sel] = m_data[g];
      sv[sel] = m_valid[g];
      mr[g]   = s_ready[sel];
    end
    return {grant, err, sa, sd, sv, mr};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_lines();
    m_address = NM'($urandom);
    m_data    = NM'($urandom);
    m_valid   = NM'($urandom);
    s_ready   = NS'($urandom);
  endtask

  // IDLE cycle, SEL_W address cycles, then the decode cycle.
  task automatic drive_select(input logic [NM-1:0] req, input int sel, input string tag,
                              output int g);
    logic [14:0]   act, exp;
    logic [NM-1:0] gv;
    next_cycle();
    m_req = req;
    randomize_lines();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, '0, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s_idle: got %b want %b", tag, act, exp);
    end
    g  = pick(req);
    gv = NM'(1) << g;
    for (int b = SW - 1; b >= 0; b--) begin
      next_cycle();
      randomize_lines();
      m_address[g]  = sel[b];
      m_req[1 - g]  = 1'($urandom);
      #1;
      act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
      exp = model_out(gv, '0, g, -1);
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL %s_addr%0d: got %b want %b", tag, b, act, exp);
      end
    end
    next_cycle();
    randomize_lines();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out(gv, '0, g, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s_pause: got %b want %b", tag, act, exp);
    end
  endtask

  // Full transaction: select, ncon routed cycles, release (or error), quiet.
  task automatic run_txn(input logic [NM-1:0] req, input int sel, input int ncon,
                         input string tag);
    logic [14:0]   act, exp;
    logic [NM-1:0] gv;
    int            g;
    drive_select(req, sel, tag, g);
    gv = NM'(1) << g;
    if (sel < NS) begin
      for (int k = 0; k < ncon; k++) begin
        next_cycle();
        randomize_lines();
        if (k % 2 == 0) m_valid[g] = 1'b1;
        m_req[1 - g] = 1'($urandom);
        #1;
        act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
        exp = model_out(gv, '0, g, sel);
        n_checks++;
        if (act !== exp) begin
          n_errors++;
          $display("FAIL %s_route%0d: got %b want %b", tag, k, act, exp);
        end
      end
      next_cycle();
      randomize_lines();
      m_valid[g] = 1'b1;
      m_req[g]   = 1'b0;
      #1;
      act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
      exp = model_out(gv, '0, g, sel);
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL %s_release: got %b want %b", tag, act, exp);
      end
    end
    next_cycle();
    m_req = '0;
    randomize_lines();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, (sel < NS) ? NM'(0) : gv, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s_after: got %b want %b", tag, act, exp);
    end
    next_cycle();
    randomize_lines();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, '0, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s_quiet: got %b want %b", tag, act, exp);
    end
    mptr = (g + 1) % NM;
  endtask

  task automatic test_reset();
    logic [14:0] act, exp;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      m_req = '1;
      randomize_lines();
      #1;
      act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
      exp = model_out('0, '0, 0, -1);
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL reset%0d: got %b want %b", k, act, exp);
      end
    end
    next_cycle();
    reset = 1'b0;
    m_req = '0;
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, '0, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL reset_exit: got %b want %b", act, exp);
    end
    mptr = 0;
  endtask

  task automatic test_contention();
    n_checks++;
    if (pick(2'b11) !== 0) begin
      n_errors++;
      $display("FAIL contention_model: got %0d want 0", pick(2'b11));
    end
    run_txn(2'b11, 1, 3, "cont_m0");
    run_txn(2'b11, 0, 3, "cont_m1");
  endtask

  task automatic test_single();
    run_txn(2'b01, 2, 4, "single");
  endtask

  task automatic test_bad_select();
    run_txn(2'b11, 3, 0, "badsel");
  endtask

  task automatic test_abort();
    logic [14:0]   act, exp;
    logic [NM-1:0] gv;
    int            g;
    next_cycle();
    m_req = 2'b01;
    randomize_lines();
    #1;
    g  = pick(2'b01);
    gv = NM'(1) << g;
    next_cycle();
    m_address[g] = 1'b1;
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out(gv, '0, g, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL abort_addr1: got %b want %b", act, exp);
    end
    next_cycle();
    m_req = '0;
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out(gv, '0, g, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL abort_addr2: got %b want %b", act, exp);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      randomize_lines();
      #1;
      act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
      exp = model_out('0, '0, 0, -1);
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL abort_idle%0d: got %b want %b", k, act, exp);
      end
    end
    mptr = (g + 1) % NM;
  endtask

  task automatic test_reset_connect();
    logic [14:0]   act, exp;
    logic [NM-1:0] gv;
    int            g;
    drive_select(2'b10, 0, "rstc", g);
    gv = NM'(1) << g;
    next_cycle();
    randomize_lines();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out(gv, '0, g, 0);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL rstc_route: got %b want %b", act, exp);
    end
    next_cycle();
    reset = 1'b1;
    #1;
    next_cycle();
    reset = 1'b0;
    m_req = '0;
    randomize_lines();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, '0, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL rstc_clear: got %b want %b", act, exp);
    end
    mptr = 0;
    run_txn(2'b11, 2, 2, "post_rst");
  endtask

  task automatic test_timeout();
    logic [14:0]   act, exp;
    logic [NM-1:0] gv;
    int            g;
    drive_select(2'b01, 1, "tmo", g);
    gv = NM'(1) << g;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      next_cycle();
      randomize_lines();
      m_valid = '0;
      #1;
      act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
      exp = model_out(gv, '0, g, 1);
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL tmo_hold%0d: got %b want %b", k, act, exp);
      end
    end
    next_cycle();
    m_req   = '0;
    m_valid = '0;
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, gv, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL tmo_release: got %b want %b", act, exp);
    end
`else
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      randomize_lines();
      m_valid = '0;
      #1;
      act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
      exp = model_out(gv, '0, g, 1);
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL hold%0d: got %b want %b", k, act, exp);
      end
    end
    next_cycle();
    m_req = '0;
    #1;
    next_cycle();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, '0, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL hold_release: got %b want %b", act, exp);
    end
`endif
    next_cycle();
    #1;
    act = {m_grant, m_err, s_address, s_data, s_valid, m_ready};
    exp = model_out('0, '0, 0, -1);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL tmo_quiet: got %b want %b", act, exp);
    end
    mptr = (g + 1) % NM;
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_txn(NM'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 5)), "rand");
    end
  endtask

  initial begin
    reset     = 1'b1;
    m_req     = '0;
    m_address = '0;
    m_data    = '0;
    m_valid   = '0;
    s_ready   = '0;
    test_reset();
    test_contention();
    test_single();
    test_bad_select();
    test_abort();
    test_reset_connect();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
